// File: rtl/mips_mem_pkg.sv
// Shared encodings, FSM states and lane helpers for the MEM pipeline stage.
// Pure declarations: no latency and no backpressure of its own.
package mips_mem_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         SIZE_BYTE: is_aligned = 1'b1;
         SIZE_HALF: is_aligned = ~lane[0];
         default:   is_aligned = (lane == 2'b00);
      endcase
   endfunction

   // Size 2'b11 is treated as a word, like SIZE_WORD.
   function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane,
                                                input logic        uns);
      logic [31:0] sh;
      logic [7:0]  b;
      logic [15:0] h;
      sh = word >> {lane, 3'b000};
      b  = sh[7:0];
      h  = sh[15:0];
      case (size)
         SIZE_BYTE: lane_extract = uns ? {24'h0, b} : {{24{b[7]}}, b};
         SIZE_HALF: lane_extract = uns ? {16'h0, h} : {{16{h[15]}}, h};
         default:   lane_extract = word;
      endcase
   endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering: store enables/replicated data and extended load data.
// Purely combinational; zero latency, no backpressure.
module load_store_align
   import mips_mem_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_lane,
   input  logic        i_uns,
   input  logic [31:0] i_store_data,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_load_data
);

   always_comb begin
      o_be    = 4'b1111;
      o_wdata = i_store_data;
      case (i_size)
         SIZE_BYTE: begin
            o_be    = 4'b0001 << i_lane;
            o_wdata = {4{i_store_data[7:0]}};
         end
         SIZE_HALF: begin
            o_be    = 4'b0011 << {i_lane[1], 1'b0};
            o_wdata = {2{i_store_data[15:0]}};
         end
         default: ;
      endcase
   end

   assign o_load_data = lane_extract(i_rdata, i_size, i_lane, i_uns);

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: passthrough in 1 cycle; loads/stores via req/ack, result 1 cycle after ack.
// Backpressure: stall holds EX/MEM from accept until the ack cycle; misaligned ops never stall.
module mem_access_stage
   import mips_mem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   input  logic [1:0]        ex_size,
   input  logic              ex_unsigned,
   input  logic [ADDR_W-1:0] ex_addr,
   input  logic [DATA_W-1:0] ex_store_data,
   input  logic [REG_W-1:0]  ex_wb_reg,
   input  logic              ex_reg_write,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   output logic [3:0]        dmem_be,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              stall,
   output logic [DATA_W-1:0] mem_data_out,
   output logic [DATA_W-1:0] alu_data_out,
   output logic [REG_W-1:0]  wb_reg_out,
   output logic              reg_write_out,
   output logic              valid_out,
   output logic              misalign_exc
);

   state_t r_state, w_state_nxt;

   logic              r_req, r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [3:0]        r_be;
   logic              r_is_load, r_uns, r_reg_write;
   logic [1:0]        r_size, r_lane;
   logic [REG_W-1:0]  r_wb_reg;
   logic [ADDR_W-1:0] r_ex_addr;

   logic [DATA_W-1:0] r_mem_data, r_alu_data;
   logic [REG_W-1:0]  r_wb_out;
   logic              r_reg_write_out, r_valid_out, r_misalign;

   logic              w_memop, w_aligned, w_start, w_misalign, w_busy;
   logic [1:0]        w_al_size, w_al_lane;
   logic              w_al_uns;
   logic [3:0]        w_be;
   logic [DATA_W-1:0] w_wdata, w_load_data;

   assign w_busy     = (r_state == ST_BUSY);
   assign w_memop    = ex_valid & (ex_mem_read | ex_mem_write);
   assign w_aligned  = is_aligned(ex_size, ex_addr[1:0]);
   assign w_start    = w_memop & w_aligned & ~w_busy;
   assign w_misalign = w_memop & ~w_aligned & ~w_busy;

   // One aligner serves both phases: store steering while idle, load extraction while busy.
   assign w_al_size = w_busy ? r_size : ex_size;
   assign w_al_lane = w_busy ? r_lane : ex_addr[1:0];
   assign w_al_uns  = w_busy ? r_uns  : ex_unsigned;

   load_store_align u_align (
      .i_size       (w_al_size),
      .i_lane       (w_al_lane),
      .i_uns        (w_al_uns),
      .i_store_data (ex_store_data),
      .i_rdata      (dmem_rdata),
      .o_be         (w_be),
      .o_wdata      (w_wdata),
      .o_load_data  (w_load_data)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      stall       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start) begin
               w_state_nxt = ST_BUSY;
               stall       = 1'b1;
            end
         end
         ST_BUSY: begin
            if (dmem_ack) w_state_nxt = ST_IDLE;
            else          stall       = 1'b1;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_req       <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_be        <= 4'b0000;
         r_is_load   <= 1'b0;
         r_uns       <= 1'b0;
         r_reg_write <= 1'b0;
         r_size      <= SIZE_BYTE;
         r_lane      <= 2'b00;
         r_wb_reg    <= '0;
         r_ex_addr   <= '0;
      end else if (w_start) begin
         r_req       <= 1'b1;
         r_we        <= ex_mem_write & ~ex_mem_read;
         r_addr      <= {ex_addr[ADDR_W-1:2], 2'b00};
         r_wdata     <= w_wdata;
         r_be        <= w_be;
         r_is_load   <= ex_mem_read;
         r_uns       <= ex_unsigned;
         r_reg_write <= ex_reg_write;
         r_size      <= ex_size;
         r_lane      <= ex_addr[1:0];
         r_wb_reg    <= ex_wb_reg;
         r_ex_addr   <= ex_addr;
      end else if (w_busy && dmem_ack) begin
         r_req <= 1'b0;
         r_we  <= 1'b0;
         r_be  <= 4'b0000;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem_data      <= '0;
         r_alu_data      <= '0;
         r_wb_out        <= '0;
         r_reg_write_out <= 1'b0;
         r_valid_out     <= 1'b0;
         r_misalign      <= 1'b0;
      end else begin
         r_misalign <= 1'b0;
         if (w_busy) begin
            if (dmem_ack) begin
               r_valid_out     <= 1'b1;
               r_reg_write_out <= r_is_load & r_reg_write;
               r_wb_out        <= r_wb_reg;
               r_alu_data      <= r_ex_addr;
               if (r_is_load) r_mem_data <= w_load_data;
            end else begin
               r_valid_out     <= 1'b0;
               r_reg_write_out <= 1'b0;
            end
         end else if (w_start) begin
            r_valid_out     <= 1'b0;
            r_reg_write_out <= 1'b0;
         end else if (w_misalign) begin
            r_valid_out     <= 1'b1;
            r_reg_write_out <= 1'b0;
            r_misalign      <= 1'b1;
            r_wb_out        <= ex_wb_reg;
            r_alu_data      <= ex_addr;
         end else begin
            r_valid_out     <= ex_valid;
            r_reg_write_out <= ex_valid & ex_reg_write;
            r_wb_out        <= ex_wb_reg;
            r_alu_data      <= ex_addr;
         end
      end
   end

   assign dmem_req      = r_req;
   assign dmem_we       = r_we;
   assign dmem_addr     = r_addr;
   assign dmem_wdata    = r_wdata;
   assign dmem_be       = r_be;
   assign mem_data_out  = r_mem_data;
   assign alu_data_out  = r_alu_data;
   assign wb_reg_out    = r_wb_out;
   assign reg_write_out = r_reg_write_out;
   assign valid_out     = r_valid_out;
   assign misalign_exc  = r_misalign;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed and randomized bench for mem_access_stage with a behavioural memory/result model.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_valid = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0;
   logic [1:0]  ex_size = 2'b00;
   logic        ex_unsigned = 1'b0;
   logic [31:0] ex_addr = 32'h0, ex_store_data = 32'h0;
   logic [4:0]  ex_wb_reg = 5'd0;
   logic        ex_reg_write = 1'b0;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack = 1'b0;
   logic [31:0] dmem_rdata = 32'h0;
   logic        stall;
   logic [31:0] mem_data_out, alu_data_out;
   logic [4:0]  wb_reg_out;
   logic        reg_write_out, valid_out, misalign_exc;

   int checks = 0;
   int errors = 0;

   mem_access_stage dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_addr(ex_addr),
      .ex_store_data(ex_store_data), .ex_wb_reg(ex_wb_reg), .ex_reg_write(ex_reg_write),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
      .dmem_rdata(dmem_rdata), .stall(stall), .mem_data_out(mem_data_out),
      .alu_data_out(alu_data_out), .wb_reg_out(wb_reg_out),
      .reg_write_out(reg_write_out), .valid_out(valid_out), .misalign_exc(misalign_exc)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Presents one instruction at a negedge, plays the memory side, and checks the
   // retirement outputs one cycle after the instruction leaves EX/MEM.
   task automatic run_op(input logic v, input logic rd, input logic wr,
                         input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] wb, input logic rw,
                         input int ack_wait, input logic [31:0] rdat);
      logic        memop, aligned, go, exp_we, stall_now, done;
      int          nb, lane, stalls, busy;
      logic [31:0] exp_ld, exp_be, exp_wd, exp_addr;

      ex_valid = v; ex_mem_read = rd; ex_mem_write = wr; ex_size = sz;
      ex_unsigned = uns; ex_addr = addr; ex_store_data = sdata;
      ex_wb_reg = wb; ex_reg_write = rw;

      nb       = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      lane     = int'(addr % 4);
      memop    = v && (rd || wr);
      aligned  = (int'(addr % 4) % nb) == 0;
      go       = memop && aligned;
      exp_we   = wr && !rd;
      exp_addr = addr - 32'(lane);
      exp_be   = (nb == 4) ? 32'd15 : (((32'd1 << nb) - 32'd1) << lane);
      if (nb == 1)      exp_wd = (sdata & 32'hFF) * 32'h0101_0101;
      else if (nb == 2) exp_wd = (sdata & 32'hFFFF) * 32'h0001_0001;
      else              exp_wd = sdata;
      exp_ld = rdat >> (8 * lane);
      if (nb == 1) begin
         exp_ld = exp_ld & 32'hFF;
         if (!uns && exp_ld >= 32'd128) exp_ld = exp_ld - 32'd256;
      end else if (nb == 2) begin
         exp_ld = exp_ld & 32'hFFFF;
         if (!uns && exp_ld >= 32'd32768) exp_ld = exp_ld - 32'd65536;
      end

      stalls = 0; busy = 0; done = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         chk("dmem_req", 32'(dmem_req), 32'(go && cyc > 0));
         if (dmem_req) begin
            chk("dmem_addr", dmem_addr, exp_addr);
            chk("dmem_we", 32'(dmem_we), 32'(exp_we));
            if (exp_we) begin
               chk("dmem_be", 32'(dmem_be), exp_be);
               chk("dmem_wdata", dmem_wdata, exp_wd);
            end
            if (busy == ack_wait) begin
               dmem_ack = 1'b1; dmem_rdata = rdat;
            end else begin
               dmem_ack = 1'b0; dmem_rdata = $urandom;
            end
            busy++;
         end
         #1;
         stall_now = stall;
         if (stall_now) stalls++;
         @(negedge clk);
         dmem_ack = 1'b0;
         if (!stall_now) begin
            done = 1'b1;
            break;
         end
      end

      chk("retire_in_budget", 32'(done), 32'd1);
      chk("stall_cycles", 32'(stalls), go ? 32'(1 + ack_wait) : 32'd0);
      chk("valid_out", 32'(valid_out), 32'(memop ? 1'b1 : v));
      chk("reg_write_out", 32'(reg_write_out), 32'(v && rw && (!memop || (go && rd))));
      chk("misalign_exc", 32'(misalign_exc), 32'(memop && !aligned));
      chk("alu_data_out", alu_data_out, addr);
      chk("wb_reg_out", 32'(wb_reg_out), 32'(wb));
      if (go && rd) chk("mem_data_out", mem_data_out, exp_ld);
   endtask

   initial begin
      logic        v, rd, wr, uns, rw;
      logic [1:0]  sz;
      logic [4:0]  wb;
      logic [31:0] addr, sdata, rdat;
      int          k, aw;

      repeat (3) @(negedge clk);
      chk("rst_dmem_req", 32'(dmem_req), 32'd0);
      chk("rst_dmem_we", 32'(dmem_we), 32'd0);
      chk("rst_dmem_be", 32'(dmem_be), 32'd0);
      chk("rst_valid_out", 32'(valid_out), 32'd0);
      chk("rst_reg_write_out", 32'(reg_write_out), 32'd0);
      chk("rst_misalign", 32'(misalign_exc), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      rst = 1'b0;

      // ALU passthrough
      run_op(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h1234, 32'h0, 5'd5, 1'b1, 0, 32'h0);
      // LB sign-extended, ack after three waiting cycles
      run_op(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 5'd7, 1'b1, 3, 32'h80FF_0000);
      chk("lb_fixed", mem_data_out, 32'hFFFF_FF80);
      // LHU, immediate ack
      run_op(1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 5'd8, 1'b1, 0, 32'hBEEF_1234);
      chk("lhu_fixed", mem_data_out, 32'h0000_BEEF);
      // SB lane 1
      run_op(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h201, 32'h0000_00AB, 5'd9, 1'b1, 1, 32'h0);
      // misaligned LW
      run_op(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h302, 32'h0, 5'd10, 1'b1, 0, 32'h0);
      // following ALU op: exception pulse has ended
      run_op(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h55AA, 32'h0, 5'd11, 1'b1, 0, 32'h0);
      // read and write together behave as a load
      run_op(1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 32'h40E, 32'h1111_2222, 5'd12, 1'b1, 2, 32'h8001_7FFF);
      // bubble carrying memory flags
      run_op(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 5'd13, 1'b1, 0, 32'h0);
      // SH upper half, SW
      run_op(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 32'h602, 32'hDEAD_C0DE, 5'd1, 1'b0, 0, 32'h0);
      run_op(1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 32'h704, 32'hCAFE_F00D, 5'd2, 1'b1, 2, 32'h0);

      // reset while an access is outstanding
      ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_size = 2'd2;
      ex_addr = 32'h800; ex_wb_reg = 5'd3; ex_reg_write = 1'b1;
      @(negedge clk);
      chk("busy_req", 32'(dmem_req), 32'd1);
      @(negedge clk);
      rst = 1'b1; ex_valid = 1'b0; ex_mem_read = 1'b0;
      @(negedge clk);
      chk("midrst_req", 32'(dmem_req), 32'd0);
      chk("midrst_be", 32'(dmem_be), 32'd0);
      chk("midrst_valid", 32'(valid_out), 32'd0);
      chk("midrst_rw", 32'(reg_write_out), 32'd0);
      chk("midrst_alu", alu_data_out, 32'd0);
      chk("midrst_stall", 32'(stall), 32'd0);
      rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
      @(negedge clk);
      dmem_ack = 1'b0;
      chk("late_ack_valid", 32'(valid_out), 32'd0);
      chk("late_ack_req", 32'(dmem_req), 32'd0);
      run_op(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h9ABC, 32'h0, 5'd4, 1'b1, 0, 32'h0);

      for (int n = 0; n < 300; n++) begin
         k     = int'($urandom_range(0, 3));
         v     = ($urandom_range(0, 9) != 0);
         rd    = (k == 1 || k == 3);
         wr    = (k == 2 || k == 3);
         sz    = 2'($urandom_range(0, 3));
         uns   = 1'($urandom_range(0, 1));
         addr  = $urandom & 32'h0000_FFFF;
         sdata = $urandom;
         wb    = 5'($urandom_range(0, 31));
         rw    = 1'($urandom_range(0, 1));
         aw    = int'($urandom_range(0, 3));
         rdat  = $urandom;
         run_op(v, rd, wr, sz, uns, addr, sdata, wb, rw, aw, rdat);
      end

      ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
